// File: rtl/circle_if.sv
// circle_if: request/response bundle for circle_engine.
//   master (controller side): drives start, centre_x/y, radius, colour,
//     octant_mask, fill; receives done and the vga_* pixel stream.
//   slave (engine side): the mirror image.
interface circle_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int R_W = 8
);
  logic           start;
  logic [X_W-1:0] centre_x;
  logic [Y_W-1:0] centre_y;
  logic [R_W-1:0] radius;
  logic [2:0]     colour;
  logic [7:0]     octant_mask;
  logic           fill;
  logic           done;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  modport master (
    output start, centre_x, centre_y, radius, colour, octant_mask, fill,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    input  start, centre_x, centre_y, radius, colour, octant_mask, fill,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle_engine.sv
// circle_engine: midpoint-circle rasteriser, one pixel per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - circle_if.slave: start/params in, done + vga_x/y/colour/plot out
// Outline mode walks octants k=0..7 per midpoint iteration; octant_mask
// gates the plot strobe, off-screen points are clipped (never wrapped).
// Optional macro CIRCLE_FILL_EN adds span (filled) mode selected by fill.
module circle_engine #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int R_W   = 8,
  parameter int X_RES = 160,
  parameter int Y_RES = 120
) (
  input logic      clk,
  input logic      rst,
  circle_if.slave  bus
);
  localparam int C_W = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int O_W = R_W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_PLOT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [O_W-1:0] S_ONE = O_W'(1);

  logic [1:0]            state;
  logic signed [O_W-1:0] ox, oy, crit;
  logic [2:0]            k;
  logic [X_W-1:0]        cx_q;
  logic [Y_W-1:0]        cy_q;
  logic [2:0]            col_q;
  logic [7:0]            mask_q;

  // midpoint step (next-iteration values)
  logic signed [O_W-1:0] oy_n, ox_n, crit_n;
  logic                  crit_le0, stop, step_now;

  // point generation
  logic signed [O_W-1:0] da, db;
  logic                  xneg, yneg, plot_en;
  logic signed [C_W-1:0] cx_s, cy_s, px, py;
  logic                  on_scr;

`ifdef CIRCLE_FILL_EN
  logic                  fill_q;
  logic signed [O_W-1:0] sx;     // x offset within current span
  logic signed [O_W-1:0] hw;     // half width of current span
  logic                  span_end;
`else
  logic unused_fill;
  assign unused_fill = bus.fill;
`endif

  always_comb begin
    oy_n     = oy + S_ONE;
    crit_le0 = crit[O_W-1] | (crit == '0);
    ox_n     = crit_le0 ? ox : ox - S_ONE;
    crit_n   = crit_le0 ? crit + (oy_n <<< 1) + S_ONE
                        : crit + ((oy_n - ox_n) <<< 1) + S_ONE;
    stop     = oy_n > ox_n;
  end

  always_comb begin
    // octants: odd k swaps the offsets; k=2..5 mirror x; k=4..7 mirror y
    da       = k[0] ? oy : ox;
    db       = k[0] ? ox : oy;
    xneg     = k[2] ^ k[1];
    yneg     = k[2];
    plot_en  = mask_q[k];
    step_now = (state == S_PLOT) && (k == 3'd7);
`ifdef CIRCLE_FILL_EN
    hw       = k[1] ? oy : ox;
    span_end = (sx == hw);
    if (fill_q) begin
      // spans: 0:+oy 1:-oy (width ox), 2:+ox 3:-ox (width oy)
      da       = sx;
      db       = k[1] ? ox : oy;
      xneg     = 1'b0;
      yneg     = k[0];
      plot_en  = 1'b1;
      step_now = (state == S_PLOT) && (k[1:0] == 2'd3) && span_end;
    end
`endif
  end

  always_comb begin
    cx_s   = $signed({{(C_W-X_W){1'b0}}, cx_q});
    cy_s   = $signed({{(C_W-Y_W){1'b0}}, cy_q});
    px     = xneg ? cx_s - C_W'(da) : cx_s + C_W'(da);
    py     = yneg ? cy_s - C_W'(db) : cy_s + C_W'(db);
    on_scr = !px[C_W-1] && (px < C_W'(X_RES)) &&
             !py[C_W-1] && (py < C_W'(Y_RES));
  end

  always_comb begin
    bus.done       = (state == S_DONE);
    bus.vga_plot   = (state == S_PLOT) && plot_en && on_scr;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    if (state == S_PLOT) begin
      bus.vga_x      = px[X_W-1:0];
      bus.vga_y      = py[Y_W-1:0];
      bus.vga_colour = col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ox     <= '0;
      oy     <= '0;
      crit   <= '0;
      k      <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      col_q  <= '0;
      mask_q <= '0;
`ifdef CIRCLE_FILL_EN
      fill_q <= 1'b0;
      sx     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) state <= S_INIT;
        S_INIT: begin
          ox     <= $signed({3'b000, bus.radius});
          oy     <= '0;
          crit   <= S_ONE - $signed({3'b000, bus.radius});
          k      <= '0;
          cx_q   <= bus.centre_x;
          cy_q   <= bus.centre_y;
          col_q  <= bus.colour;
          mask_q <= bus.octant_mask;
`ifdef CIRCLE_FILL_EN
          fill_q <= bus.fill;
          sx     <= -$signed({3'b000, bus.radius});
`endif
          state  <= S_PLOT;
        end
        S_PLOT: begin
`ifdef CIRCLE_FILL_EN
          if (fill_q) begin
            if (!span_end)             sx <= sx + S_ONE;
            else if (k[1:0] != 2'd3) begin
              k  <= k + 3'd1;
              sx <= (k[1:0] == 2'd0) ? -ox : -oy;
            end else begin
              k  <= '0;
              sx <= -ox_n;
            end
          end else
`endif
          k <= k + 3'd1;
          if (step_now) begin
            oy   <= oy_n;
            ox   <= ox_n;
            crit <= crit_n;
            if (stop) state <= S_DONE;
          end
        end
        S_DONE: if (!bus.start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circle_engine.sv
// tb_circle_engine: directed vectors with hand-computed expectations for
// circle_engine (outline, clipping, masking, reset abort, optional fill).
module tb_circle_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circle_if #(.X_W(8), .Y_W(7), .R_W(8)) bus ();

  circle_engine #(.X_W(8), .Y_W(7), .R_W(8), .X_RES(160), .Y_RES(120)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int qx[$];
  int qy[$];
  int done_cyc;
  int last_col;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int cx, input int cy, input int r, input int m, input int f);
    bus.centre_x    = 8'(cx);
    bus.centre_y    = 7'(cy);
    bus.radius      = 8'(r);
    bus.octant_mask = 8'(m);
    bus.fill        = 1'(f);
    bus.colour      = 3'd5;
  endtask

  // raise start, collect plotted pixels until done (cycle 1 = INIT)
  task automatic run_draw(input int budget);
    qx.delete();
    qy.delete();
    done_cyc  = -1;
    last_col  = -1;
    bus.start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (bus.vga_plot) begin
        qx.push_back(int'(bus.vga_x));
        qy.push_back(int'(bus.vga_y));
        last_col = int'(bus.vga_colour);
      end
    end
    if (done_cyc < 0) chk("timeout", 0, 1);
  endtask

  task automatic release_start();
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  int ex1[16] = '{81,80,79,80,79,80,81,80, 81,81,79,79,79,79,81,81};
  int ey1[16] = '{60,61,60,61,60,59,60,59, 61,61,61,61,59,59,59,59};
  int efx[20] = '{9,10,11,9,10,11,10,10, 9,10,11,9,10,11,9,10,11,9,10,11};
  int efy[20] = '{10,10,10,10,10,10,11,9, 11,11,11,9,9,9,11,11,11,9,9,9};

  initial begin
    int nb, nr, d2;
    bus.start = 1'b0;
    setup(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_done",   int'(bus.done), 0);
    chk("rst_plot",   int'(bus.vga_plot), 0);
    chk("rst_x",      int'(bus.vga_x), 0);
    chk("rst_y",      int'(bus.vga_y), 0);
    chk("rst_colour", int'(bus.vga_colour), 0);
    rst = 1'b0;
    tick();

    // r=0: 8 plot cycles at the centre
    setup(80, 60, 0, 'hFF, 0);
    run_draw(50);
    chk("r0_done", done_cyc, 10);
    chk("r0_nplot", qx.size(), 8);
    nb = 0;
    foreach (qx[i]) if (qx[i] != 80 || qy[i] != 60) nb++;
    chk("r0_pts", nb, 0);
    chk("r0_colour", last_col, 5);
    release_start();

    // r=1: two iterations, then done holds until start drops
    setup(80, 60, 1, 'hFF, 0);
    run_draw(50);
    chk("r1_done", done_cyc, 18);
    chk("r1_nplot", qx.size(), 16);
    for (int i = 0; i < 16 && i < qx.size(); i++) begin
      chk($sformatf("r1_x%0d", i), qx[i], ex1[i]);
      chk($sformatf("r1_y%0d", i), qy[i], ey1[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_hold", int'(bus.done), 1);
    end
    bus.start = 1'b0;
    tick();
    chk("r1_release", int'(bus.done), 0);
    tick();

    // r=10 at origin: 8 iterations, only non-negative points plotted
    setup(0, 0, 10, 'hFF, 0);
    run_draw(200);
    chk("clip_done", done_cyc, 66);
    chk("clip_nplot", qx.size(), 18);
    nb = 0;
    foreach (qx[i]) if (qx[i] >= 160 || qy[i] >= 120) nb++;
    chk("clip_range", nb, 0);
    release_start();

    // r=30, mask 0x03: 22 iterations, octants 0/1 only
    setup(80, 60, 30, 'h03, 0);
    run_draw(400);
    chk("mask_done", done_cyc, 178);
    chk("mask_nplot", qx.size(), 44);
    nb = 0;
    nr = 0;
    foreach (qx[i]) begin
      if (qx[i] < 80 || qy[i] < 60) nb++;
      d2 = (qx[i] - 80) * (qx[i] - 80) + (qy[i] - 60) * (qy[i] - 60);
      if (d2 < 870 || d2 > 930) nr++;
    end
    chk("mask_quadrant", nb, 0);
    chk("mask_radius", nr, 0);
    release_start();

    // reset in the middle of PLOT aborts to IDLE
    setup(80, 60, 30, 'hFF, 0);
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("abort_done",   int'(bus.done), 0);
    chk("abort_plot",   int'(bus.vga_plot), 0);
    chk("abort_x",      int'(bus.vga_x), 0);
    chk("abort_y",      int'(bus.vga_y), 0);
    chk("abort_colour", int'(bus.vga_colour), 0);
    rst = 1'b0;
    tick();
    setup(80, 60, 0, 'hFF, 0);
    run_draw(50);
    chk("redraw_done", done_cyc, 10);
    chk("redraw_nplot", qx.size(), 8);
    release_start();

`ifdef CIRCLE_FILL_EN
    // filled r=1: 8 + 12 span pixels, mask ignored
    setup(10, 10, 1, 'h00, 1);
    run_draw(100);
    chk("fill_done", done_cyc, 22);
    chk("fill_nplot", qx.size(), 20);
    for (int i = 0; i < 20 && i < qx.size(); i++) begin
      chk($sformatf("fill_x%0d", i), qx[i], efx[i]);
      chk($sformatf("fill_y%0d", i), qy[i], efy[i]);
    end
    release_start();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circle_engine.md
# circle_engine

Parametrised midpoint-circle rasteriser for the VGA datapath. It generalises the lab's fixed 160×120 circle drawer with configurable coordinate widths and screen bounds, a per-octant enable mask for arc and Reuleaux-style shapes, and screen clipping. An optional filled mode is also available. It sits between a top-level controller (KEY/SW decode or sequencer) and the VGA adapter's `x/y/colour/plot` inputs, issuing one pixel per clock.

## Interface
Parameters:
- `X_W`, 8: width of x coordinates and centre_x.
- `Y_W`, 7: width of y coordinates and centre_y.
- `R_W`, 8: radius width.
- `X_RES`, 160: pixels per row; x ≥ X_RES is off-screen.
- `Y_RES`, 120: rows; y ≥ Y_RES is off-screen.

Ports:
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level request; held high until `done`.
- `centre_x` in X_W: centre x, sampled in INIT.
- `centre_y` in Y_W: centre y, sampled in INIT.
- `radius` in R_W: radius, sampled in INIT.
- `colour` in 3: pixel colour, sampled in INIT.
- `octant_mask` in 8: bit k enables octant k, sampled in INIT.
- `fill` in 1: filled mode select, sampled in INIT. Only effective with CIRCLE_FILL_EN.
- `done` out 1: drawing complete.
- `vga_x` out X_W: pixel x coordinate.
- `vga_y` out Y_W: pixel y coordinate.
- `vga_colour` out 3: pixel colour.
- `vga_plot` out 1: pixel write strobe.

## Operation
- States: IDLE, INIT, PLOT, DONE. On reset, go to IDLE.
- IDLE → INIT when `start`=1.
- INIT loads the following, then → PLOT:
  - oy=0, ox=radius, crit=1−radius.
  - Octant counter k=0.
  - Latched inputs.
- Outline PLOT:
  - One cycle per octant k=0..7, producing the following points:
    - (cx+ox, cy+oy), (cx+oy, cy+ox), (cx−ox, cy+oy), (cx−oy, cy+ox)
    - (cx−ox, cy−oy), (cx−oy, cy−ox), (cx+ox, cy−oy), (cx+oy, cy−ox)
  - Step update at k=7:
    - oy+=1.
    - If crit≤0: crit+=2·oy+1.
    - Else: ox−=1, then crit+=2·(oy−ox)+1. Both updates use the new values.
  - If new oy > new ox, go to DONE. Otherwise k=0 and repeat.
- `vga_plot`=1 only when both conditions hold:
  - `octant_mask[k]`=1.
  - The point is on screen: 0≤x<X_RES and 0≤y<Y_RES.
- A masked or clipped octant still consumes its cycle. Cycle count therefore depends only on radius.
- Arithmetic:
  - ox, oy and crit are signed, R_W+3 bits.
  - Coordinates are computed signed at max(X_W,Y_W)+2 bits before clipping. There is no wrap-around, so negative values are clipped, never aliased.
- DONE: `done`=1 and `vga_plot`=0. Stays in DONE while `start`=1; → IDLE the cycle after `start`=0.
- If `start` drops mid-draw, drawing completes anyway. `done` is then high for exactly one cycle.
- `rst` mid-draw aborts immediately to IDLE.

## Timing
- Reset/IDLE output values: `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
- All outputs are registered-state driven. During PLOT cycle k, the outputs reflect octant k; there is no extra latency.
- Latency:
  - `start` seen → INIT: 1 cycle.
  - First PLOT cycle follows INIT.
  - `done` rises 1 + 8·N cycles after INIT begins, where N is the iteration count.
- The VGA adapter writes on every `clk` with `vga_plot`=1. The engine never stalls.

## Configuration
- `CIRCLE_FILL_EN` defined: `fill`=1 selects span mode.
  - Each iteration emits four horizontal spans, one pixel per cycle, left to right:
    - y=cy+oy and y=cy−oy, x from cx−ox to cx+ox.
    - y=cy+ox and y=cy−ox, x from cx−oy to cx+oy.
  - `octant_mask` is ignored.
  - Off-screen pixels are clipped but still consume cycles.
  - Duplicate pixels are permitted (e.g. when oy=0).
- `CIRCLE_FILL_EN` undefined: the span logic is absent, `fill` is ignored, and behaviour is outline only.

## Test plan
- r=0, centre (80,60), mask 0xFF → 8 plot cycles, all at (80,60). `done` 10 cycles after `start` (IDLE→INIT→8 PLOT→DONE).
- r=1, centre (80,60), mask 0xFF → 16 plot cycles:
  - First 8 points: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Second 8 points at offsets (1,1).
  - `done` then holds while `start`=1 and clears one cycle after `start`=0.
- Centre (0,0), r=10, mask 0xFF → only points with x≥0 and y≥0 carry `vga_plot`=1. Total PLOT cycles equal the unclipped count for r=10.
- Centre (80,60), r=30, mask 0x03 → `vga_plot` only on octants 0 and 1. Every plotted pixel lies in the x≥80, y≥60 quadrant.
- Reset asserted during PLOT → the next cycle is IDLE with all outputs 0. A new `start` redraws from scratch.
- With CIRCLE_FILL_EN, r=1, fill=1, centre (10,10) → pixels plotted:
  - Spans (9..11, 10) ×2 and (10, 9..11) in the first iteration.
  - Then (9..11, 11), (9..11, 9) and their mirrors.
  - No pixel outside the 3×3 box.
